counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencer for the team's WIDTH-bit up-counter (clk_i/rst_i/en_i/data_o). It clears the counter, enables it for exactly a programmed number of increments, and then stops it. It supports pause, abort and completion signalling, so a counter run is a single start command instead of hand-driven en/rst sequences.

Parameters:
WIDTH, 4, width of the controlled counter and of limit_i/cnt_data_i
GAP, 2, idle cycles between automatic runs (only used with CNT_SEQ_AUTORELOAD_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  start a run (level sampled each edge)
stop_i  in  1  abort current run
pause_i  in  1  hold counter while high during a run
limit_i  in  WIDTH  number of increments; latched on accepted start
cnt_data_i  in  WIDTH  counter data_o feedback
cnt_en_o  out  1  drives counter en_i
cnt_clr_o  out  1  drives counter active-high sync clear (counter rst_i)
busy_o  out  1  high in CLEAR/RUN/PAUSE
done_o  out  1  one-cycle pulse on normal completion
err_o  out  1  sticky: start_i seen while not IDLE
state_o  out  3  IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4, WAIT=5

Behaviour:
- All outputs registered. On rst_i low: state IDLE; cnt_en_o, cnt_clr_o, busy_o, done_o and err_o are 0; limit_q is 0.
- IDLE: start_i=1 → CLEAR. Latch limit_i into limit_q and clear err_o.
- CLEAR: cnt_clr_o=1 for exactly one cycle. Next state: RUN if limit_q≠0, else DONE (counter left at 0).
- RUN: cnt_en_o=1. Terminal condition: cnt_en_o=1 and cnt_data_i==limit_q-1. On that edge: counter increments to limit_q, cnt_en_o falls, state → DONE. The counter stops exactly at limit_q, with no overshoot and no wrap.
- RUN with pause_i=1 (no terminal) → PAUSE; cnt_en_o=0 from the next cycle.
- PAUSE: cnt_en_o=0, counter holds. pause_i=0 → RUN (enable resumes next cycle).
- DONE: done_o=1 for one cycle → IDLE.
- stop_i in CLEAR/RUN/PAUSE → IDLE next cycle. cnt_en_o drops and done_o is not asserted. Counter keeps its value, including the increment made on the stop edge.
- Priority within one edge: stop_i > terminal > pause_i.
- start_i while state≠IDLE: ignored, err_o←1 (sticky until next accepted start or reset).
- Latency, start sampled at edge N with limit L>0: cnt_clr_o high N→N+1; cnt_en_o high N+2→N+2+L (L increments); counter=L after edge N+2+L; done_o high N+2+L→N+3+L.
- limit_i changes during a run are ignored (limit_q is used).
- Reset asserted mid-run: all outputs 0 immediately (asynchronous). The counter keeps its value until the next CLEAR.

Optional Feature:
CNT_SEQ_AUTORELOAD_EN
- Defined: DONE → WAIT. WAIT holds all controls low for GAP cycles, then → CLEAR with the same limit_q; done_o pulses on every pass. busy_o=0 in WAIT. stop_i in WAIT → IDLE. start_i in WAIT sets err_o. Only stop_i or reset ends the loop.
- Not defined: DONE → IDLE; the WAIT state is not implemented.

Test Plan:
- Reset, then start_i=1 for 1 cycle with limit_i=5 → cnt_clr_o 1 cycle; cnt_en_o high 5 cycles; counter ends at 5; done_o pulse 7 cycles after start; busy_o then 0.
- limit_i=0 → CLEAR then DONE; cnt_en_o never high; counter=0; done_o pulse.
- limit_i=15, pause_i high 3 cycles mid-run → counter holds during pause; final count 15 (no wrap to 0); cnt_en_o total 15 cycles.
- stop_i pulse while counter=3 of limit 10 → IDLE next cycle; done_o stays 0; counter 3 or 4 per the stop-edge rule; new start recounts from 0.
- start_i during RUN → ignored, err_o=1; run completes normally; next accepted start clears err_o.
- rst_i low mid-RUN → all outputs 0 asynchronously; state_o=0. With CNT_SEQ_AUTORELOAD_EN: limit 3 → done_o pulses every 3+2+GAP+... cycles repeatedly until stop_i.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer that clears, runs and stops an external WIDTH-bit up-counter
//
// A run is one start command: clear the counter, enable it for exactly limit
// increments, then stop it and pulse done_o. Pause, abort and misuse reporting
// are included.
//
// Optional feature macro: CNT_SEQ_AUTORELOAD_EN
//   defined   : after DONE the sequencer idles GAP cycles in WAIT, then reruns
//               with the same limit until stop_i or reset
//   undefined : DONE returns to IDLE, no WAIT state exists
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous reset, active-low
//   start_i     start a run (level, sampled each edge)
//   stop_i      abort the current run
//   pause_i     hold the counter while high during a run
//   limit_i     number of increments, latched on an accepted start
//   cnt_data_i  counter value fed back from the counter
//   cnt_en_o    counter enable
//   cnt_clr_o   counter synchronous clear (active-high)
//   busy_o      high in CLEAR/RUN/PAUSE
//   done_o      one-cycle pulse on normal completion
//   err_o       sticky: start_i seen while not IDLE
//   state_o     IDLE=0 CLEAR=1 RUN=2 PAUSE=3 DONE=4 WAIT=5
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [WIDTH-1:0] cnt_data_i,
    output logic             cnt_en_o,
    output logic             cnt_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
`ifdef CNT_SEQ_AUTORELOAD_EN
        , WAIT = 3'd5
`endif
    } state_t;

    if (GAP < 1) begin : g_bad_gap
        $error("counter_seq_ctrl: GAP must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             err_q, err_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             term;

`ifdef CNT_SEQ_AUTORELOAD_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GW-1:0] gap_q, gap_d;
`endif

    // The increment on this edge brings the counter to limit_q.
    assign term = en_q && (cnt_data_i == limit_q - WIDTH'(1));

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        err_d   = err_q;
`ifdef CNT_SEQ_AUTORELOAD_EN
        gap_d   = gap_q;
`endif
        if (start_i && state_q != IDLE) err_d = 1'b1;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = CLEAR;
                limit_d = limit_i;
                err_d   = 1'b0;
            end
            CLEAR: state_d = stop_i ? IDLE : (limit_q != '0) ? RUN : DONE;
            RUN:   state_d = stop_i ? IDLE : term ? DONE : pause_i ? PAUSE : RUN;
            PAUSE: state_d = stop_i ? IDLE : pause_i ? PAUSE : RUN;
`ifdef CNT_SEQ_AUTORELOAD_EN
            DONE: begin
                state_d = WAIT;
                gap_d   = '0;
            end
            WAIT: begin
                state_d = stop_i ? IDLE : (gap_q == GW'(GAP - 1)) ? CLEAR : WAIT;
                gap_d   = gap_q + GW'(1);
            end
`else
            DONE:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        clr_d  = state_d == CLEAR;
        // The first RUN cycle after CLEAR keeps the enable low so the clear
        // lands before counting starts.
        en_d   = state_d == RUN && state_q != CLEAR;
        busy_d = state_d == CLEAR || state_d == RUN || state_d == PAUSE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            limit_q <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CNT_SEQ_AUTORELOAD_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            err_q   <= err_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CNT_SEQ_AUTORELOAD_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign cnt_en_o  = en_q;
    assign cnt_clr_o = clr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed self-checking bench for counter_seq_ctrl with a counter model
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, pause;
    logic [3:0] limit;
    logic [3:0] cnt = 4'd0;
    logic       en, clr, busy, done, err;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;
    int         en_edges = 0;
    int         n;
    int         seen;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(4), .GAP(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
        .limit_i(limit), .cnt_data_i(cnt), .cnt_en_o(en), .cnt_clr_o(clr),
        .busy_o(busy), .done_o(done), .err_o(err), .state_o(state)
    );

    // The controlled up-counter.
    always @(posedge clk) begin
        if (clr) cnt <= 4'd0;
        else if (en) cnt <= cnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (en) en_edges++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        en_edges = 0;
        start = 1'b1;
        limit = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < max);
        if (!done) cycles = -1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; limit = 4'd0;
        tick(); tick();
        chk("rst_en", en, 0); chk("rst_clr", clr, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_state", state, 0);
        rst_n = 1'b1;
        tick();
`ifdef CNT_SEQ_AUTORELOAD_EN
        do_start(4'd3);
        wait_done(20, n);
        chk("ar_first", n, 5); chk("ar_cnt", cnt, 3);
        wait_done(20, n);
        chk("ar_period1", n, 8);
        wait_done(20, n);
        chk("ar_period2", n, 8); chk("ar_cnt2", cnt, 3);
        tick();
        chk("ar_wait", state, 5); chk("ar_wait_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_wait_err", err, 1); chk("ar_wait_hold", state, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("ar_stop", state, 0);
        tick(); tick(); tick(); tick();
        chk("ar_stays_idle", state, 0); chk("ar_no_done", done, 0);
`else
        // limit 5, limit_i changed mid-run must be ignored
        do_start(4'd5);
        chk("t1_clr", clr, 1); chk("t1_state_clear", state, 1); chk("t1_busy", busy, 1);
        limit = 4'd9;
        tick();
        chk("t1_clr_once", clr, 0); chk("t1_en_late", en, 0); chk("t1_cleared", cnt, 0);
        chk("t1_state_run", state, 2);
        wait_done(40, n);
        chk("t1_latency", n, 6); chk("t1_cnt", cnt, 5); chk("t1_en_edges", en_edges, 5);
        chk("t1_en_off", en, 0);
        tick();
        chk("t1_done_pulse", done, 0); chk("t1_idle_busy", busy, 0); chk("t1_idle", state, 0);
        // limit 0
        do_start(4'd0);
        wait_done(10, n);
        chk("t2_latency", n, 1); chk("t2_cnt", cnt, 0); chk("t2_en_edges", en_edges, 0);
        tick();
        chk("t2_idle", state, 0);
        // limit 15 with a 3-cycle pause
        do_start(4'd15);
        tick(); tick(); tick(); tick();
        chk("t3_pre_pause", cnt, 2);
        pause = 1'b1;
        tick();
        chk("t3_pause_state", state, 3); chk("t3_pause_en", en, 0); chk("t3_pause_cnt", cnt, 3);
        tick(); tick();
        chk("t3_hold_cnt", cnt, 3); chk("t3_hold_busy", busy, 1);
        pause = 1'b0;
        tick();
        chk("t3_resume_state", state, 2); chk("t3_resume_en", en, 1);
        wait_done(40, n);
        chk("t3_latency", n, 12); chk("t3_cnt_nowrap", cnt, 15); chk("t3_en_edges", en_edges, 15);
        tick();
        // stop at count 3 of 10
        do_start(4'd10);
        tick(); tick(); tick(); tick(); tick();
        chk("t4_pre_stop", cnt, 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_state", state, 0); chk("t4_stop_en", en, 0); chk("t4_stop_busy", busy, 0);
        chk("t4_stop_cnt", cnt, 4);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen++;
            tick();
        end
        chk("t4_no_done", seen, 0); chk("t4_cnt_kept", cnt, 4);
        do_start(4'd2);
        tick();
        chk("t4_recount_clear", cnt, 0);
        wait_done(20, n);
        chk("t4_recount_latency", n, 3); chk("t4_recount_cnt", cnt, 2);
        tick();
        // start during RUN
        do_start(4'd6);
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_err", err, 1); chk("t5_ignored", state, 2);
        wait_done(20, n);
        chk("t5_latency", n, 4); chk("t5_cnt", cnt, 6); chk("t5_err_sticky", err, 1);
        tick();
        do_start(4'd1);
        chk("t5_err_cleared", err, 0);
        wait_done(20, n);
        chk("t5_l1_latency", n, 3); chk("t5_l1_cnt", cnt, 1);
        tick();
        // asynchronous reset mid-run
        do_start(4'd8);
        tick(); tick(); tick();
        chk("t6_running", en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_en", en, 0); chk("t6_busy", busy, 0); chk("t6_state", state, 0);
        chk("t6_clr", clr, 0); chk("t6_done", done, 0);
        @(posedge clk);
        #1;
        chk("t6_cnt_kept", cnt, 1);
        rst_n = 1'b1;
        tick();
        do_start(4'd3);
        wait_done(20, n);
        chk("t6_after_latency", n, 5); chk("t6_after_cnt", cnt, 3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
